parking_gate_controller: RTL and testbench

- Controls a single shared-lane gate for the parking lot.
- Arbitrates between cars waiting to enter and cars waiting to leave.
- Keeps the lot occupancy count, using the enter/exit pass pulses from the lane sensor FSM.
- Blocks entry when the lot is full, and auto-closes the gate if no car passes within a timeout.

---
 rtl/parking_gate_if.sv | 41 ++++
 rtl/parking_gate_controller.sv | 134 +++++++++++++
 tb/tb_parking_gate_controller.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_gate_if.sv
// parking_gate_if
//   Bundles the lane-side signals of the parking gate controller.
//   Handshake semantics: enter_req/exit_req are levels that are only looked at
//   while the controller is idle; enter_pulse/exit_pulse are single-cycle
//   strobes meaning "a car finished passing"; there is no ready/ack, the gate
//   outputs themselves are the grant.
//   Ports (signals):
//     enter_req, exit_req       : car waiting at entry / exit side
//     enter_pulse, exit_pulse   : car completed entry / exit
//     gate_in, gate_out         : gate open inbound / outbound
//     occupancy, full, empty    : lot count and its decodes
//     timeout_evt               : one-cycle pulse, gate closed on timeout
//     error                     : sticky unexpected-pulse flag
//     fsm_state                 : controller state, for observation
//   Modports: master drives requests/pulses, slave is the controller.
interface parking_gate_if #(
    parameter int CNT_W = 4
);
    logic             enter_req;
    logic             exit_req;
    logic             enter_pulse;
    logic             exit_pulse;
    logic             gate_in;
    logic             gate_out;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             timeout_evt;
    logic             error;
    logic [1:0]       fsm_state;

    modport master (
        output enter_req, exit_req, enter_pulse, exit_pulse,
        input  gate_in, gate_out, occupancy, full, empty, timeout_evt, error, fsm_state
    );

    modport slave (
        input  enter_req, exit_req, enter_pulse, exit_pulse,
        output gate_in, gate_out, occupancy, full, empty, timeout_evt, error, fsm_state
    );
endinterface

// File: rtl/parking_gate_controller.sv
// parking_gate_controller
//   Single shared-lane gate arbiter for the parking lot. Grants the lane to
//   entering or leaving cars, alternating on ties, keeps the occupancy count
//   from the sensor pass pulses, refuses entry when full and closes the gate
//   if no car passes within TIMEOUT cycles.
//   Ports:
//     clk   : system clock
//     reset : asynchronous, active-high
//     bus   : parking_gate_if.slave (requests, pulses, gates, status, state)
module parking_gate_controller #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int TIMEOUT  = 16,
    parameter int TMR_W    = 5
) (
    input  logic           clk,
    input  logic           reset,
    parking_gate_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IN  = 2'd1,
        GRANT_OUT = 2'd2,
        COOLDOWN  = 2'd3
    } state_t;

    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT - 1);

    state_t           state;
    dir_t             last_dir;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] occupancy;
    logic             timeout_evt;
    logic             error;

    logic full;
    logic empty;
    logic elig_in;
    logic elig_out;

    assign full     = (occupancy == CAP_V);
    assign empty    = (occupancy == '0);
    assign elig_in  = bus.enter_req && !full;
    assign elig_out = bus.exit_req && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_dir    <= DIR_OUT;
            timer       <= '0;
            occupancy   <= '0;
            timeout_evt <= 1'b0;
            error       <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enter_pulse || bus.exit_pulse) begin
                        error <= 1'b1;
                    end
                    // On a tie, serve the direction not served last time.
                    if (elig_in && (!elig_out || last_dir == DIR_OUT)) begin
                        state <= GRANT_IN;
                        timer <= '0;
                    end else if (elig_out) begin
                        state <= GRANT_OUT;
                        timer <= '0;
                    end
                end
                GRANT_IN: begin
                    timer <= timer + TMR_W'(1);
                    if (bus.exit_pulse) begin
                        error <= 1'b1;
                    end
                    // A pass on the last timer cycle wins over the timeout.
                    if (bus.enter_pulse) begin
                        if (occupancy != CAP_V) begin
                            occupancy <= occupancy + CNT_W'(1);
                        end
                        last_dir <= DIR_IN;
                        state    <= COOLDOWN;
                    end else if (timer == TMR_END) begin
                        timeout_evt <= 1'b1;
                        last_dir    <= DIR_IN;
                        state       <= COOLDOWN;
                    end
                end
                GRANT_OUT: begin
                    timer <= timer + TMR_W'(1);
                    if (bus.enter_pulse) begin
                        error <= 1'b1;
                    end
                    if (bus.exit_pulse) begin
                        if (occupancy != '0) begin
                            occupancy <= occupancy - CNT_W'(1);
                        end
                        last_dir <= DIR_OUT;
                        state    <= COOLDOWN;
                    end else if (timer == TMR_END) begin
                        timeout_evt <= 1'b1;
                        last_dir    <= DIR_OUT;
                        state       <= COOLDOWN;
                    end
                end
                COOLDOWN: begin
                    if (bus.enter_pulse || bus.exit_pulse) begin
                        error <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gates are Moore decodes of the state register, so an asynchronous
    // reset drops them at once.
    assign bus.gate_in     = (state == GRANT_IN);
    assign bus.gate_out    = (state == GRANT_OUT);
    assign bus.occupancy   = occupancy;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.timeout_evt = timeout_evt;
    assign bus.error       = error;
    assign bus.fsm_state   = state;

endmodule

// File: tb/tb_parking_gate_controller.sv
module tb_parking_gate_controller;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    parking_gate_if #(.CNT_W(4)) bus ();

    parking_gate_controller #(
        .CAPACITY(8),
        .CNT_W   (4),
        .TIMEOUT (16),
        .TMR_W   (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       er;
        logic       xr;
        logic       ep;
        logic       xp;
        logic       gi;
        logic       go;
        logic [3:0] occ;
        logic       full;
        logic       empty;
        logic       tevt;
        logic       err;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic er, input logic xr, input logic ep, input logic xp);
        bus.enter_req   = er;
        bus.exit_req    = xr;
        bus.enter_pulse = ep;
        bus.exit_pulse  = xp;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0);
        #12;
        reset = 1'b0;
        step();
    endtask

    task automatic check_idle_status(input string tag, input int occ, input int err);
        check({tag, "_gate_in"}, int'(bus.gate_in), 0);
        check({tag, "_gate_out"}, int'(bus.gate_out), 0);
        check({tag, "_occ"}, int'(bus.occupancy), occ);
        check({tag, "_empty"}, int'(bus.empty), (occ == 0) ? 1 : 0);
        check({tag, "_full"}, int'(bus.full), (occ == 8) ? 1 : 0);
        check({tag, "_err"}, int'(bus.error), err);
    endtask

    // Wait (bounded) for the requested gate to open; counts as a comparison.
    task automatic wait_gate(input bit dir_in, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dir_in ? bus.gate_in : bus.gate_out) begin
                hit = 1'b1;
                break;
            end
        end
        check(name, int'(hit), 1);
    endtask

    // One full pass; returns with the controller back in IDLE.
    task automatic do_pass(input bit dir_in, input string name);
        if (dir_in) bus.enter_req = 1'b1;
        else        bus.exit_req  = 1'b1;
        wait_gate(dir_in, name);
        bus.enter_req = 1'b0;
        bus.exit_req  = 1'b0;
        if (dir_in) bus.enter_pulse = 1'b1;
        else        bus.exit_pulse  = 1'b1;
        step();
        bus.enter_pulse = 1'b0;
        bus.exit_pulse  = 1'b0;
        step();
    endtask

    initial begin
        int cnt;
        bit seen;

        n_cmp = 0;
        n_bad = 0;

        // er xr ep xp | gi go occ full empty tevt err
        vecs[0]  = '{1, 0, 0, 0, 1, 0, 4'd0, 0, 1, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 1, 0, 4'd0, 0, 1, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 1, 0, 4'd0, 0, 1, 0, 0};
        vecs[3]  = '{1, 0, 1, 0, 0, 0, 4'd1, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0, 0, 0, 4'd1, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 1, 0, 4'd1, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 0, 0, 0, 4'd2, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 4'd2, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 1, 0, 0, 4'd2, 0, 0, 0, 1};
        vecs[9]  = '{0, 1, 0, 0, 0, 1, 4'd2, 0, 0, 0, 1};
        vecs[10] = '{0, 1, 1, 0, 0, 1, 4'd2, 0, 0, 0, 1};
        vecs[11] = '{0, 0, 1, 1, 0, 0, 4'd1, 0, 0, 0, 1};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 4'd1, 0, 0, 0, 1};
        vecs[13] = '{0, 1, 0, 0, 0, 1, 4'd1, 0, 0, 0, 1};
        vecs[14] = '{0, 0, 0, 1, 0, 0, 4'd0, 0, 1, 0, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 4'd0, 0, 1, 0, 1};

        do_reset();
        check_idle_status("rst", 0, 0);
        check("rst_tevt", int'(bus.timeout_evt), 0);

        // table-driven vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].er, vecs[i].xr, vecs[i].ep, vecs[i].xp);
            step();
            check($sformatf("v%0d_gate_in", i), int'(bus.gate_in), int'(vecs[i].gi));
            check($sformatf("v%0d_gate_out", i), int'(bus.gate_out), int'(vecs[i].go));
            check($sformatf("v%0d_occ", i), int'(bus.occupancy), int'(vecs[i].occ));
            check($sformatf("v%0d_full", i), int'(bus.full), int'(vecs[i].full));
            check($sformatf("v%0d_empty", i), int'(bus.empty), int'(vecs[i].empty));
            check($sformatf("v%0d_tevt", i), int'(bus.timeout_evt), int'(vecs[i].tevt));
            check($sformatf("v%0d_err", i), int'(bus.error), int'(vecs[i].err));
        end
        drive(0, 0, 0, 0);

        // mid-run asynchronous reset during a grant
        do_pass(1'b1, "pre_rst_entry");
        bus.enter_req = 1'b1;
        wait_gate(1'b1, "pre_rst_grant");
        #2;
        reset = 1'b1;
        #1;
        check_idle_status("async_rst", 0, 0);
        bus.enter_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        check_idle_status("after_rst", 0, 0);

        // fill the lot
        for (int i = 0; i < 8; i++) begin
            do_pass(1'b1, $sformatf("fill%0d", i));
        end
        check_idle_status("full", 8, 0);
        bus.enter_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.gate_in) seen = 1'b1;
        end
        check("full_blocks_entry", int'(seen), 0);
        bus.exit_req = 1'b1;
        step();
        check("full_exit_grant", int'(bus.gate_out), 1);
        bus.exit_req    = 1'b0;
        bus.enter_req   = 1'b0;
        bus.exit_pulse  = 1'b1;
        step();
        bus.exit_pulse = 1'b0;
        check_idle_status("after_exit_full", 7, 0);

        // tie arbitration with last_dir = IN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_pass(1'b1, $sformatf("tie_fill%0d", i));
        end
        drive(1, 1, 0, 0);
        step();
        check("tie1_gate_out", int'(bus.gate_out), 1);
        check("tie1_gate_in", int'(bus.gate_in), 0);
        bus.exit_pulse = 1'b1;
        step();
        bus.exit_pulse = 1'b0;
        check("tie1_occ", int'(bus.occupancy), 2);
        step();
        step();
        check("tie2_gate_in", int'(bus.gate_in), 1);
        check("tie2_gate_out", int'(bus.gate_out), 0);
        drive(0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0);
        step();
        check_idle_status("tie_end", 3, 0);

        // timeout: gate open exactly 16 cycles, then one timeout_evt cycle
        bus.enter_req = 1'b1;
        wait_gate(1'b1, "to_grant");
        bus.enter_req = 1'b0;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.gate_in) cnt++;
            else break;
        end
        check("to_open_cycles", cnt, 16);
        check("to_evt", int'(bus.timeout_evt), 1);
        check("to_occ", int'(bus.occupancy), 3);
        step();
        check("to_evt_clear", int'(bus.timeout_evt), 0);
        check_idle_status("to_end", 3, 0);

        // exit_pulse during GRANT_IN: error, no count change, grant continues
        bus.enter_req = 1'b1;
        wait_gate(1'b1, "err_grant");
        bus.enter_req  = 1'b0;
        bus.exit_pulse = 1'b1;
        step();
        bus.exit_pulse = 1'b0;
        check("err_gin_flag", int'(bus.error), 1);
        check("err_gin_occ", int'(bus.occupancy), 3);
        check("err_gin_gate", int'(bus.gate_in), 1);
        bus.enter_pulse = 1'b1;
        step();
        bus.enter_pulse = 1'b0;
        step();
        check_idle_status("err_sticky", 4, 1);
        do_reset();
        check_idle_status("err_cleared", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
